// File: rtl/bist_misr_controller.sv
// bist_misr_controller
//   BIST sequencer and output-response compactor for the s9234 scan wrapper.
//   Runs NUM_PATTERNS shift/capture loops followed by a final unload. The 7
//   scan-out chains are folded into a 7-bit MISR (x^7+x^6+1), and the final
//   signature is compared against GOLDEN_SIG.
//
// Ports
//   CK            in   clock, all state on rising edge
//   COMP_reset_n  in   async active-low reset
//   start         in   begin a run (honoured only in IDLE or DONE)
//   abort         in   synchronous return to IDLE, has priority over start
//   so_chain[6:0] in   scan-out of chains 7..1 (bit0 = chain1)
//   TPG_reset     out  holds the wrapper TPG at its seed
//   bist_en       out  selects the TPG as scan-in source
//   scan_en       out  1 = shift, 0 = capture
//   signature     out  MISR contents
//   busy          out  run in progress (state not IDLE/DONE)
//   done          out  run completed, sticky until start/abort/reset
//   pass          out  done && signature == GOLDEN_SIG
//   dbg_state     out  current FSM state encoding
//
// Handshake: start is a level sampled on each rising edge while the FSM is in
// IDLE or DONE. The result (signature/pass) is valid while done=1 and stays
// valid until the next accepted start, an abort, or reset.
module bist_misr_controller #(
  parameter int CHAIN_LEN             = 33,
  parameter int NUM_PATTERNS          = 128,
  parameter logic [6:0] GOLDEN_SIG    = 7'h00
) (
  input  logic       CK,
  input  logic       COMP_reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] so_chain,
  output logic       TPG_reset,
  output logic       bist_en,
  output logic       scan_en,
  output logic [6:0] signature,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] dbg_state
);

  localparam int SW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int PW = $clog2(NUM_PATTERNS + 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_MAX    = PW'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    UNLOAD  = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [SW-1:0]   shift_cnt, shift_cnt_next;
  logic [PW-1:0]   pat_cnt, pat_cnt_next, pat_inc;
  logic [6:0]      misr_step, sig_next;
  logic            compact_en;

  assign dbg_state = state;

  // Saturating pattern increment used both for the counter and the exit test.
  assign pat_inc = (pat_cnt == PAT_MAX) ? PAT_MAX : pat_cnt + PW'(1);

  // The very first load is never compacted: the chains still hold
  // uninitialised flop contents at that point.
  assign compact_en = ((state == SHIFT) && (pat_cnt != '0)) || (state == UNLOAD);

  always_comb begin
    misr_step    = '0;
    misr_step[0] = signature[6] ^ so_chain[0];
    for (int i = 1; i < 6; i++) begin
      misr_step[i] = signature[i-1] ^ so_chain[i];
    end
    misr_step[6] = signature[5] ^ signature[6] ^ so_chain[6];
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_next = INIT;
        INIT:       state_next = SHIFT;
        SHIFT:      if (shift_cnt == SHIFT_LAST) state_next = CAPTURE;
        CAPTURE:    state_next = (pat_inc >= PAT_MAX) ? UNLOAD : SHIFT;
        UNLOAD:     if (shift_cnt == SHIFT_LAST) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  // Datapath next values. The so_chain mux keeps unknown scan-out data away
  // from the signature whenever compaction is off.
  always_comb begin
    sig_next       = signature;
    pat_cnt_next   = pat_cnt;
    shift_cnt_next = '0;
    if (!abort) begin
      if (state == INIT) begin
        sig_next = '0;
      end else if (compact_en) begin
        sig_next = misr_step;
      end
    end
    if (state == INIT) begin
      pat_cnt_next = '0;
    end else if (state == CAPTURE) begin
      pat_cnt_next = pat_inc;
    end
    // Shift counter runs only while staying in a shifting state; any exit
    // (including abort) returns it to zero.
    if ((state_next == state) && ((state == SHIFT) || (state == UNLOAD))) begin
      shift_cnt_next = shift_cnt + SW'(1);
    end
  end

  always_ff @(posedge CK or negedge COMP_reset_n) begin
    if (!COMP_reset_n) begin
      state     <= IDLE;
      shift_cnt <= '0;
      pat_cnt   <= '0;
      signature <= '0;
      TPG_reset <= 1'b1;
      bist_en   <= 1'b0;
      scan_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_next;
      shift_cnt <= shift_cnt_next;
      pat_cnt   <= pat_cnt_next;
      signature <= sig_next;
      // Control outputs are registered from the next state so they line up
      // exactly with the state they describe.
      TPG_reset <= (state_next == IDLE) || (state_next == INIT) || (state_next == DONE);
      bist_en   <= (state_next == INIT) || (state_next == SHIFT) ||
                   (state_next == CAPTURE) || (state_next == UNLOAD);
      scan_en   <= (state_next == INIT) || (state_next == SHIFT) || (state_next == UNLOAD);
      busy      <= (state_next != IDLE) && (state_next != DONE);
      done      <= (state_next == DONE);
      pass      <= (state_next == DONE) && (sig_next == GOLDEN_SIG);
    end
  end

endmodule

// File: tb/tb_bist_misr_controller.sv
// tb_bist_misr_controller
//   Directed bench for bist_misr_controller with CHAIN_LEN=3, NUM_PATTERNS=2.
//   Each run pushes its hand-computed {pass, signature} and completion cycle
//   into queues; a monitor pops them when done rises.
module tb_bist_misr_controller;

  logic       CK;
  logic       COMP_reset_n;
  logic       start;
  logic       abort;
  logic [6:0] so_chain;
  logic       TPG_reset;
  logic       bist_en;
  logic       scan_en;
  logic [6:0] signature;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] dbg_state;

  bist_misr_controller #(
    .CHAIN_LEN    (3),
    .NUM_PATTERNS (2),
    .GOLDEN_SIG   (7'h00)
  ) dut (
    .CK           (CK),
    .COMP_reset_n (COMP_reset_n),
    .start        (start),
    .abort        (abort),
    .so_chain     (so_chain),
    .TPG_reset    (TPG_reset),
    .bist_en      (bist_en),
    .scan_en      (scan_en),
    .signature    (signature),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CK = 1'b0;
  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  logic [6:0] so_vec [0:12];
  logic       done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a rising done is the DUT presenting a result.
  always @(negedge CK) begin
    if (COMP_reset_n && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h expected=none", {pass, signature});
      end else begin
        check("result_pass_sig", {pass, signature}, exp_q.pop_front());
        check("done_cycle", cyc, exp_cyc_q.pop_front());
      end
    end
    done_prev <= done;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic fill_so(input logic [6:0] d);
    for (int i = 0; i <= 12; i++) so_vec[i] = d;
  endtask

  // Expected {TPG_reset, bist_en, scan_en, busy, done} k cycles after start.
  // k=1 INIT, 2..4 SHIFT, 5 CAPTURE, 6..8 SHIFT, 9 CAPTURE, 10..12 UNLOAD.
  function automatic logic [4:0] exp_ctrl(input int k);
    logic cap;
    cap = (k == 5) || (k == 9);
    return {(k == 1), 1'b1, !cap, 1'b1, 1'b0};
  endfunction

  task automatic run_test(input logic [7:0] exp_ps, input int start_pulse_k);
    int t0;
    int w;
    step();
    t0 = cyc;
    start = 1'b1;
    so_chain = so_vec[0];
    exp_q.push_back(exp_ps);
    exp_cyc_q.push_back(t0 + 13);
    for (int k = 1; k <= 12; k++) begin
      step();
      start = (k == start_pulse_k);
      so_chain = so_vec[k];
      check($sformatf("ctrl_k%0d", k), {TPG_reset, bist_en, scan_en, busy, done}, exp_ctrl(k));
      if (k == 1) check("pass_cleared", pass, 1'b0);
      if (k == 2) check("init_clears_sig", signature, 7'h00);
    end
    step();
    start = 1'b0;
    so_chain = 7'h00;
    w = 0;
    while (!done && w < 8) begin
      step();
      w++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1");
    end else begin
      check("done_ctrl", {TPG_reset, bist_en, scan_en, busy}, 4'b1000);
    end
    @(negedge CK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    COMP_reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    so_chain = 7'h00;
    repeat (3) @(posedge CK);
    @(negedge CK);
    check("rst_sig", signature, 7'h00);
    check("rst_ctrl", {TPG_reset, bist_en, scan_en, busy, done, pass}, 6'b100000);
    check("rst_state", dbg_state, 3'd0);
    step();
    COMP_reset_n = 1'b1;

    // All-zero response, with an ignored start pulse mid-run.
    fill_so(7'h00);
    run_test({1'b1, 7'h00}, 6);

    // First load full of ones is masked.
    fill_so(7'h00);
    for (int k = 2; k <= 4; k++) so_vec[k] = 7'h7F;
    run_test({1'b1, 7'h00}, 0);

    // Single 1 on chain1 at the first compacted cycle, shifted five times.
    fill_so(7'h00);
    so_vec[6] = 7'h01;
    run_test({1'b0, 7'h20}, 0);

    // Data only in INIT/CAPTURE (ignored) plus a 1 in the last unload cycle.
    fill_so(7'h00);
    so_vec[1] = 7'h7F;
    so_vec[5] = 7'h7F;
    so_vec[9] = 7'h7F;
    so_vec[12] = 7'h01;
    run_test({1'b0, 7'h01}, 0);

    // Feedback tap: 0x20 -> 0x40 -> 0x41.
    fill_so(7'h00);
    so_vec[10] = 7'h20;
    run_test({1'b0, 7'h41}, 0);

    // All ones every cycle: 7F,40,3E,03,79,4C over the six compacted cycles.
    fill_so(7'h7F);
    run_test({1'b0, 7'h4C}, 0);

    // Abort in the second CAPTURE; signature must be retained.
    fill_so(7'h00);
    so_vec[6] = 7'h01;
    step();
    start = 1'b1;
    so_chain = so_vec[0];
    for (int k = 1; k <= 9; k++) begin
      step();
      start = 1'b0;
      so_chain = so_vec[k];
    end
    check("pre_abort_sig", signature, 7'h04);
    abort = 1'b1;
    step();
    abort = 1'b0;
    so_chain = 7'h7F;
    check("abort_ctrl", {TPG_reset, bist_en, scan_en, busy, done, pass}, 6'b100000);
    check("abort_sig_held", signature, 7'h04);
    check("abort_state", dbg_state, 3'd0);
    step();
    check("idle_sig_held", signature, 7'h04);

    // abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    so_chain = 7'h00;
    check("abort_beats_start", {busy, dbg_state}, 4'b0000);

    // Restart after abort runs a full, correctly timed run.
    fill_so(7'h00);
    run_test({1'b1, 7'h00}, 0);

    // Asynchronous reset mid-cycle during a run.
    fill_so(7'h7F);
    step();
    start = 1'b1;
    so_chain = 7'h7F;
    for (int k = 1; k <= 8; k++) begin
      step();
      start = 1'b0;
    end
    check("pre_reset_sig", signature, 7'h40);
    #3;
    COMP_reset_n = 1'b0;
    #1;
    check("async_rst_sig", signature, 7'h00);
    check("async_rst_ctrl", {TPG_reset, bist_en, scan_en, busy, done, pass}, 6'b100000);
    so_chain = 7'h00;
    step();
    step();
    COMP_reset_n = 1'b1;
    step();
    check("post_reset_idle", {busy, dbg_state}, 4'b0000);

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
